// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of stores sharing the single data-memory
// port with loads; loads that hit a buffered word stall until that store drains.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        sb_empty,
    output logic [1:0]  MemWrite,
    output logic [31:0] a,
    output logic [31:0] wd
);

    localparam int PW = $clog2(DEPTH);

    logic [1:0]    size_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          hit;
    logic          push;
    logic          drain;

    // An entry is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - head_q} < count_q) &&
                (addr_q[i][31:2] == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_stall = ld_req & hit;
    assign st_ready = !reset && (count_q != (PW+1)'(DEPTH));
    assign sb_empty = (count_q == '0);
    assign push     = st_valid & st_ready;
    // A stalled load yields the port, so the matching store always gets out.
    assign drain    = !reset && (count_q != '0) && (!ld_req || ld_stall);

    always_comb begin
        MemWrite = 2'b00;
        a        = 32'h0;
        wd       = 32'h0;
        if (drain) begin
            MemWrite = size_q[head_q];
            a        = addr_q[head_q];
            wd       = data_q[head_q];
        end else if (ld_req) begin
            a        = ld_addr;
        end
    end

    always_comb begin
        head_d  = drain ? head_q + 1'b1 : head_q;
        tail_d  = push  ? tail_q + 1'b1 : tail_q;
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: liveness is defined purely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            size_q[tail_q] <= st_size;
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table plus a queue-based reference model
// that predicts every output and scoreboards memory writes in push order.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        sb_empty;
    logic [1:0]  MemWrite;
    logic [31:0] a;
    logic [31:0] wd;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .sb_empty(sb_empty), .MemWrite(MemWrite), .a(a), .wd(wd)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ent_t;

    typedef struct {
        logic        stv;
        logic [1:0]  sz;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lr;
        logic [31:0] la;
        logic        rdy;
        logic        stall;
        logic        empty;
        logic [1:0]  mw;
        logic [31:0] ea;
        logic [31:0] ewd;
    } vec_t;

    ent_t exp_q[$];
    vec_t vt[11];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [1:0] sz, input logic [31:0] sa,
                         input logic [31:0] sd, input logic lr, input logic [31:0] la);
        st_valid = sv;
        st_size  = sz;
        st_addr  = sa;
        st_data  = sd;
        ld_req   = lr;
        ld_addr  = la;
    endtask

    // One cycle against the reference model; acc reports whether the store was taken.
    task automatic step(input string tag, input logic sv, input logic [1:0] sz,
                        input logic [31:0] sa, input logic [31:0] sd,
                        input logic lr, input logic [31:0] la, output logic acc);
        logic        h, dr, rdy;
        logic [1:0]  emw;
        logic [31:0] ea, ewd;
        ent_t        tmp;
        @(negedge clk);
        drive(sv, sz, sa, sd, lr, la);
        #1;
        h = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].addr[31:2] == la[31:2]) h = 1'b1;
        h   = h & lr;
        dr  = (exp_q.size() != 0) && (!lr || h);
        rdy = (exp_q.size() < 4);
        emw = 2'b00; ea = 32'h0; ewd = 32'h0;
        if (dr) begin
            emw = exp_q[0].size; ea = exp_q[0].addr; ewd = exp_q[0].data;
        end else if (lr) begin
            ea = la;
        end
        chk({tag, ".st_ready"}, {31'h0, st_ready}, {31'h0, rdy});
        chk({tag, ".ld_stall"}, {31'h0, ld_stall}, {31'h0, h});
        chk({tag, ".sb_empty"}, {31'h0, sb_empty}, {31'h0, exp_q.size() == 0});
        chk({tag, ".MemWrite"}, {30'h0, MemWrite}, {30'h0, emw});
        chk({tag, ".a"}, a, ea);
        chk({tag, ".wd"}, wd, ewd);
        if (dr) tmp = exp_q.pop_front();
        acc = sv && rdy;
        if (acc) exp_q.push_back('{sa, sd, sz});
    endtask

    task automatic drain_all(input string tag);
        logic acc;
        for (int c = 0; c < 16 && exp_q.size() != 0; c++)
            step(tag, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, acc);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk({tag, ".final_empty"}, {31'h0, sb_empty}, 32'h1);
    endtask

    initial begin
        logic acc;
        int   pushes;
        int   k;

        //        stv sz     sa            sd            lr  la           rdy stall empty mw    a             wd
        vt[0]  = '{0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1, 0, 1, 2'b00, 32'h0,        32'h0};
        vt[1]  = '{1, 2'b01, 32'h10,       32'hDEADBEEF, 0, 32'h0,        1, 0, 1, 2'b00, 32'h0,        32'h0};
        vt[2]  = '{0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1, 0, 0, 2'b01, 32'h10,       32'hDEADBEEF};
        vt[3]  = '{0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1, 0, 1, 2'b00, 32'h0,        32'h0};
        vt[4]  = '{1, 2'b11, 32'h21,       32'hAA,       0, 32'h0,        1, 0, 1, 2'b00, 32'h0,        32'h0};
        vt[5]  = '{0, 2'b00, 32'h0,        32'h0,        1, 32'h20,       1, 1, 0, 2'b11, 32'h21,       32'hAA};
        vt[6]  = '{0, 2'b00, 32'h0,        32'h0,        1, 32'h20,       1, 0, 1, 2'b00, 32'h20,       32'h0};
        vt[7]  = '{1, 2'b01, 32'h40,       32'h11111111, 1, 32'h40,       1, 0, 1, 2'b00, 32'h40,       32'h0};
        vt[8]  = '{0, 2'b00, 32'h0,        32'h0,        1, 32'h44,       1, 0, 0, 2'b00, 32'h44,       32'h0};
        vt[9]  = '{0, 2'b00, 32'h0,        32'h0,        1, 32'h42,       1, 1, 0, 2'b01, 32'h40,       32'h11111111};
        vt[10] = '{0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        1, 0, 1, 2'b00, 32'h0,        32'h0};

        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst.st_ready", {31'h0, st_ready}, 32'h0);
            chk("rst.MemWrite", {30'h0, MemWrite}, 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vt[i].stv, vt[i].sz, vt[i].sa, vt[i].sd, vt[i].lr, vt[i].la);
            #1;
            chk($sformatf("vec%0d.st_ready", i), {31'h0, st_ready}, {31'h0, vt[i].rdy});
            chk($sformatf("vec%0d.ld_stall", i), {31'h0, ld_stall}, {31'h0, vt[i].stall});
            chk($sformatf("vec%0d.sb_empty", i), {31'h0, sb_empty}, {31'h0, vt[i].empty});
            chk($sformatf("vec%0d.MemWrite", i), {30'h0, MemWrite}, {30'h0, vt[i].mw});
            chk($sformatf("vec%0d.a", i), a, vt[i].ea);
            chk($sformatf("vec%0d.wd", i), wd, vt[i].ewd);
        end

        // Fill behind a non-matching load stream; fifth store must be refused.
        for (int i = 0; i < 5; i++)
            step($sformatf("fill%0d", i), 1'b1, 2'b01, 32'h400 + 32'(i) * 4,
                 32'hF000_0000 + 32'(i), 1'b1, 32'h100, acc);
        step("fill_full_drain", 1'b1, 2'b01, 32'h410, 32'hF000_0004, 1'b0, 32'h0, acc);
        step("fill_retry", 1'b1, 2'b01, 32'h410, 32'hF000_0004, 1'b0, 32'h0, acc);
        drain_all("fill_drain");

        // Push and drain in the same cycle at count 2.
        step("pd0", 1'b1, 2'b01, 32'h500, 32'hA0A0A0A0, 1'b1, 32'h100, acc);
        step("pd1", 1'b1, 2'b10, 32'h506, 32'h0000B1B1, 1'b1, 32'h100, acc);
        step("pd2", 1'b1, 2'b11, 32'h509, 32'h000000C2, 1'b0, 32'h0, acc);
        step("pd3", 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h508, acc);
        drain_all("pd_drain");

        // Ten mixed stores with interleaved non-matching loads; pointers wrap.
        pushes = 0;
        k = 0;
        for (int cyc = 0; cyc < 200 && pushes < 10; cyc++) begin
            logic        sv, lr;
            logic [1:0]  sz;
            logic [31:0] sa;
            sv = ($urandom_range(0, 3) != 0);
            lr = ($urandom_range(0, 2) == 0);
            sz = 2'(k % 3 + 1);
            sa = 32'h200 + 32'(k) * 4;
            if (sz == 2'b10) sa = sa + 32'((k % 2) * 2);
            if (sz == 2'b11) sa = sa + 32'(k % 4);
            step($sformatf("wrap%0d", cyc), sv, sz, sa, $urandom, lr,
                 32'h1000 + 32'(cyc) * 4, acc);
            if (acc) begin
                pushes++;
                k++;
            end
        end
        chk("wrap.pushes", 32'(pushes), 32'd10);
        drain_all("wrap_drain");

        // Reset with two entries buffered: nothing may reach memory afterwards.
        step("rm0", 1'b1, 2'b01, 32'h300, 32'h12345678, 1'b1, 32'h100, acc);
        step("rm1", 1'b1, 2'b11, 32'h305, 32'h00000099, 1'b1, 32'h100, acc);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rm.rst_st_ready", {31'h0, st_ready}, 32'h0);
        chk("rm.rst_MemWrite", {30'h0, MemWrite}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        step("rm_after", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, acc);
        step("rm_ld", 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h304, acc);
        step("rm_idle", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
